// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run controller: FSM state encoding and
// the fail_code values reported on a terminal stop.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        StReset,
        StHold,
        StRun,
        StDone,
        StFail
    } state_e;

    typedef logic [1:0] fail_code_t;

    localparam fail_code_t FAIL_NONE    = 2'b00;
    localparam fail_code_t FAIL_ERR     = 2'b01;
    localparam fail_code_t FAIL_TIMEOUT = 2'b10;
    localparam fail_code_t FAIL_STALL   = 2'b11;

endpackage

// File: rtl/run_ctrl_if.sv
// Processor-facing signal bundle of the run controller. The slave modport is the
// controller's view; the master modport is the processor/observer side.
interface run_ctrl_if
    import run_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
);

    logic             halt;
    logic             err;
    logic             kick;
    logic             core_rst;
    logic             running;
    logic             stop;
    fail_code_t       fail_code;
    logic [CNT_W-1:0] cycle_cnt;

    modport slave (
        input  halt, err, kick,
        output core_rst, running, stop, fail_code, cycle_cnt
    );

    modport master (
        output halt, err, kick,
        input  core_rst, running, stop, fail_code, cycle_cnt
    );

endinterface

// File: rtl/rst_sync.sv
// Reset synchronizer: asserts asynchronously, deasserts through two flops.
// rst_n_stage1 is exposed so the consumer can act on the very edge at which
// rst_n_sync deasserts.
module rst_sync (
    input  logic clk,
    input  logic rst_n,
    output logic rst_n_sync,
    output logic rst_n_stage1
);

    logic meta_q;
    logic sync_q;

    // Two-stage shift of a constant 1, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= 1'b1;
            sync_q <= meta_q;
        end
    end

    assign rst_n_stage1 = meta_q;
    assign rst_n_sync   = sync_q;

endmodule

// File: rtl/run_ctrl.sv
// Run controller: sequences processor reset release, supervises the RUN phase
// and latches a terminal DONE/FAIL verdict until the next reset.
// Optional feature: define RUN_CTRL_STALL_WDT_EN to build the kick-based stall
// watchdog (fail_code 11); without it kick is ignored.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES  = 2,
    parameter int unsigned MAX_CYCLES   = 100000,
    parameter int unsigned STALL_CYCLES = 1024,
    parameter int unsigned CNT_W        = 32
) (
    input logic        clk,
    input logic        rst_n,
    run_ctrl_if.slave  bus
);

    logic rst_n_sync;
    logic rst_n_stage1;

    rst_sync u_rst_sync (
        .clk          (clk),
        .rst_n        (rst_n),
        .rst_n_sync   (rst_n_sync),
        .rst_n_stage1 (rst_n_stage1)
    );

    // High on the edge where the synchronized reset deasserts.
    logic sync_release;
    assign sync_release = rst_n_stage1 & ~rst_n_sync;

    state_e           state_q, state_d;
    logic [7:0]       hold_q, hold_d;
    logic [CNT_W-1:0] cycle_q, cycle_d, cycle_inc;
    logic             stop_q, stop_d;
    fail_code_t       code_q, code_d;

`ifdef RUN_CTRL_STALL_WDT_EN
    localparam int unsigned StallW = $clog2(STALL_CYCLES + 1);
    logic [StallW-1:0] stall_q, stall_d;
`else
    logic unused_kick;
    assign unused_kick = bus.kick;
`endif

    // Saturating RUN-cycle increment.
    assign cycle_inc = (&cycle_q) ? cycle_q : cycle_q + CNT_W'(1);

    // State and counter registers; rst_n forces reset values immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StReset;
            hold_q  <= '0;
            cycle_q <= '0;
            stop_q  <= 1'b0;
            code_q  <= FAIL_NONE;
`ifdef RUN_CTRL_STALL_WDT_EN
            stall_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cycle_q <= cycle_d;
            stop_q  <= stop_d;
            code_q  <= code_d;
`ifdef RUN_CTRL_STALL_WDT_EN
            stall_q <= stall_d;
`endif
        end
    end

    // Next-state logic; in RUN the checks run err > halt > timeout > stall.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cycle_d = cycle_q;
        stop_d  = stop_q;
        code_d  = code_q;
`ifdef RUN_CTRL_STALL_WDT_EN
        stall_d = stall_q;
`endif
        case (state_q)
            StReset: begin
                if (sync_release) begin
                    state_d = StHold;
                    hold_d  = '0;
                end
            end
            StHold: begin
                hold_d = hold_q + 8'd1;
                if (32'(hold_q) == HOLD_CYCLES - 1) begin
                    state_d = StRun;
`ifdef RUN_CTRL_STALL_WDT_EN
                    stall_d = '0;
`endif
                end
            end
            StRun: begin
                cycle_d = cycle_inc;
`ifdef RUN_CTRL_STALL_WDT_EN
                stall_d = bus.kick ? '0 : stall_q + StallW'(1);
`endif
                if (bus.err) begin
                    state_d = StFail;
                    stop_d  = 1'b1;
                    code_d  = FAIL_ERR;
                end else if (bus.halt) begin
                    state_d = StDone;
                    stop_d  = 1'b1;
                    code_d  = FAIL_NONE;
                end else if (64'(cycle_inc) == 64'(MAX_CYCLES)) begin
                    state_d = StFail;
                    stop_d  = 1'b1;
                    code_d  = FAIL_TIMEOUT;
                end
`ifdef RUN_CTRL_STALL_WDT_EN
                else if (32'(stall_d) == STALL_CYCLES) begin
                    state_d = StFail;
                    stop_d  = 1'b1;
                    code_d  = FAIL_STALL;
                end
`endif
            end
            StDone, StFail: begin
            end
            default: begin
                state_d = StReset;
            end
        endcase
    end

    assign bus.core_rst  = (state_q == StReset) || (state_q == StHold);
    assign bus.running   = (state_q == StRun);
    assign bus.stop      = stop_q;
    assign bus.fail_code = code_q;
    assign bus.cycle_cnt = cycle_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: reset sequencing, directed terminal cases
// and randomized RUN-phase stimulus against a cycle-level behavioural model.
module tb_run_ctrl;

    localparam int unsigned HOLD  = 2;
    localparam int unsigned MAXC  = 100;
    localparam int unsigned STALL = 16;
`ifdef RUN_CTRL_STALL_WDT_EN
    localparam bit WDT = 1'b1;
`else
    localparam bit WDT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    run_ctrl_if #(.CNT_W(32)) bus ();

    run_ctrl #(
        .HOLD_CYCLES  (HOLD),
        .MAX_CYCLES   (MAXC),
        .STALL_CYCLES (STALL),
        .CNT_W        (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of the RUN phase.
    longint m_cyc;
    bit     m_stop;
    int     m_code;
    int     m_idle;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input bit h, input bit e, input bit k);
        bus.halt = h;
        bus.err  = e;
        bus.kick = k;
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, ".core_rst"}, 64'(bus.core_rst), 64'd1);
        check_val({tag, ".running"}, 64'(bus.running), 64'd0);
        check_val({tag, ".stop"}, 64'(bus.stop), 64'd0);
        check_val({tag, ".fail_code"}, 64'(bus.fail_code), 64'd0);
        check_val({tag, ".cycle_cnt"}, 64'(bus.cycle_cnt), 64'd0);
    endtask

    task automatic model_step(input bit h, input bit e, input bit k);
        if (m_stop) return;
        if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
        m_idle = k ? 0 : m_idle + 1;
        if (e) begin
            m_stop = 1; m_code = 1;
        end else if (h) begin
            m_stop = 1; m_code = 0;
        end else if (m_cyc == MAXC) begin
            m_stop = 1; m_code = 2;
        end else if (WDT && m_idle == STALL) begin
            m_stop = 1; m_code = 3;
        end
    endtask

    // Assert reset (checked without a clock edge), release it and check that
    // core_rst drops and running rises on the 4th edge after release. Inputs
    // toggle randomly throughout and must have no effect.
    task automatic reset_seq();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        repeat (2) begin
            @(negedge clk);
            drive(1'($urandom), 1'($urandom), 1'($urandom));
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom));
            @(posedge clk);
            #1;
            check_val($sformatf("seq_e%0d.core_rst", e), 64'(bus.core_rst), 64'(e < 4));
            check_val($sformatf("seq_e%0d.running", e), 64'(bus.running), 64'(e == 4));
            check_val($sformatf("seq_e%0d.stop", e), 64'(bus.stop), 64'd0);
            @(negedge clk);
        end
        check_val("seq.cycle_cnt", 64'(bus.cycle_cnt), 64'd0);
        m_cyc = 0; m_stop = 0; m_code = 0; m_idle = 0;
    endtask

    // Modes: 0 halt at cycle 50, 1 err+halt together, 2 timeout, 3 random,
    // 4 kicks then silence, 5 reset mid-RUN.
    task automatic run_episode(input int mode, input int trig);
        bit h, e, k;
        int after;
        after = 0;
        for (int c = 0; c < 220; c++) begin
            k = (m_cyc % 10) == 0;
            h = 1'b0;
            e = 1'b0;
            case (mode)
                0: h = (m_cyc == 50);
                1: begin h = (m_cyc == trig); e = (m_cyc == trig); end
                3: begin
                    e = ($urandom_range(0, 40) == 0);
                    h = ($urandom_range(0, 40) == 0);
                    k = ($urandom_range(0, 3) == 0);
                end
                4: k = (m_cyc < 40) && (m_cyc % 10 == 0);
                default: ;
            endcase
            if (m_stop) begin
                h = 1'($urandom); e = 1'($urandom); k = 1'($urandom);
            end
            drive(h, e, k);
            @(posedge clk);
            #1;
            model_step(h, e, k);
            check_val($sformatf("m%0d.stop", mode), 64'(bus.stop), 64'(m_stop));
            check_val($sformatf("m%0d.fail_code", mode), 64'(bus.fail_code), 64'(m_code));
            check_val($sformatf("m%0d.cycle_cnt", mode), 64'(bus.cycle_cnt), 64'(m_cyc));
            check_val($sformatf("m%0d.running", mode), 64'(bus.running), 64'(!m_stop));
            check_val($sformatf("m%0d.core_rst", mode), 64'(bus.core_rst), 64'd0);
            if (mode == 5 && c == trig) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_reset_vals("mid_run_rst");
                break;
            end
            @(negedge clk);
            if (m_stop) begin
                after++;
                if (after == 5) break;
            end
        end
    endtask

    initial begin
        int t;
        drive(1'b0, 1'b0, 1'b0);

        reset_seq();
        run_episode(0, 0);
        check_val("halt50.fail_code", 64'(bus.fail_code), 64'd0);
        check_val("halt50.cycle_cnt", 64'(bus.cycle_cnt), 64'd51);
        check_val("halt50.stop", 64'(bus.stop), 64'd1);

        reset_seq();
        t = $urandom_range(5, 60);
        run_episode(1, t);
        check_val("err_halt.fail_code", 64'(bus.fail_code), 64'd1);
        check_val("err_halt.cycle_cnt", 64'(bus.cycle_cnt), 64'(t + 1));

        reset_seq();
        run_episode(2, 0);
        check_val("timeout.fail_code", 64'(bus.fail_code), 64'd2);
        check_val("timeout.cycle_cnt", 64'(bus.cycle_cnt), 64'(MAXC));

        reset_seq();
        run_episode(4, 0);
        // Last kick is sampled on the edge reaching cycle 31; stall 16 edges later.
        check_val("stall.fail_code", 64'(bus.fail_code), WDT ? 64'd3 : 64'd2);
        check_val("stall.cycle_cnt", 64'(bus.cycle_cnt), WDT ? 64'd47 : 64'(MAXC));

        reset_seq();
        run_episode(5, $urandom_range(5, 60));
        reset_seq();
        run_episode(0, 0);
        check_val("post_rst.cycle_cnt", 64'(bus.cycle_cnt), 64'd51);

        for (int i = 0; i < 6; i++) begin
            reset_seq();
            run_episode(3, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 2, meaning core reset cycles held after synchronized reset release (legal 1..255).
REQ-002 SHALL have parameter MAX_CYCLES, default 100000, meaning RUN-cycle timeout limit.
REQ-003 SHALL have parameter STALL_CYCLES, default 1024, meaning cycles without kick before stall fail.
REQ-004 SHALL have parameter CNT_W, default 32, meaning cycle counter width.
REQ-005 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port halt  input  1  processor halted (level).
REQ-008 SHALL have port err  input  1  processor error (level).
REQ-009 SHALL have port kick  input  1  forward-progress pulse (e.g. retire).
REQ-010 SHALL have port core_rst  output  1  active-high reset to processor.
REQ-011 SHALL have port running  output  1  state is RUN.
REQ-012 SHALL have port stop  output  1  terminal state reached (DONE or FAIL).
REQ-013 SHALL have port fail_code  output  2  00 none, 01 ERR, 10 TIMEOUT, 11 STALL.
REQ-014 SHALL have port cycle_cnt  output  CNT_W  RUN cycles elapsed.

Function
REQ-015 SHALL implement states RESET, HOLD, RUN, DONE, FAIL.
REQ-016 SHALL leave RESET for HOLD on the first edge where the synchronized reset is deasserted, clearing hold_cnt to 0.
REQ-017 SHALL increment hold_cnt each HOLD edge and go to RUN on the edge where hold_cnt == HOLD_CYCLES-1.
REQ-018 SHALL drive core_rst=1 in RESET and HOLD, and 0 from the edge entering RUN onward.
REQ-019 SHALL ignore halt, err and kick outside RUN.
REQ-020 SHALL increment cycle_cnt by 1 on every RUN edge, saturating at all-ones, and freeze it in DONE/FAIL.
REQ-021 SHALL in RUN apply priority err > halt > timeout > stall on each edge.
REQ-022 SHALL go to FAIL with code 01 when err=1 in RUN.
REQ-023 SHALL go to DONE with code 00 when halt=1 and err=0 in RUN.
REQ-024 SHALL go to FAIL with code 10 on the edge where cycle_cnt increments to MAX_CYCLES, if neither err nor halt.
REQ-025 SHALL register stop and fail_code, asserting them on the same edge as the terminal-state entry.
REQ-026 SHALL hold DONE/FAIL, stop and fail_code until rst_n is asserted.

Reset
REQ-027 SHALL asynchronously force, while rst_n=0: state RESET, core_rst=1, running=0, stop=0, fail_code=00, cycle_cnt=0, hold_cnt=0, stall_cnt=0.
REQ-028 SHALL deassert internal reset only via a 2-flop synchronizer, so RESET exits on the 2nd edge after rst_n rises.
REQ-029 SHALL honour rst_n assertion in any state, including mid-HOLD and mid-RUN, immediately returning to RESET values.

Configuration
REQ-030 SHALL compile the stall watchdog only when RUN_CTRL_STALL_WDT_EN is defined.
REQ-031 SHALL with the macro: clear stall_cnt on kick or RUN entry, else increment it in RUN, and go to FAIL code 11 when stall_cnt reaches STALL_CYCLES (lowest priority).
REQ-032 SHALL without the macro: contain no stall counter, ignore kick, and never produce code 11.

Structure
REQ-033 SHALL place the state enum and FAIL_* code constants in the shared package run_ctrl_pkg.
REQ-034 SHALL instantiate one sub-module rst_sync (async-assert, 2-flop sync-deassert, active-low in and out).

Verification
REQ-035 SHALL verify: rst_n rises, HOLD_CYCLES=2 -> core_rst falls on the 4th edge after the rise; running=1 on the same edge.
REQ-036 SHALL verify: halt=1 at RUN cycle 50 -> stop=1, fail_code=00, cycle_cnt frozen at 51.
REQ-037 SHALL verify: err=1 and halt=1 on the same edge -> fail_code=01.
REQ-038 SHALL verify: MAX_CYCLES=100, no halt -> stop=1, fail_code=10, cycle_cnt=100.
REQ-039 SHALL verify: rst_n pulsed low mid-RUN -> all outputs at reset values without waiting for a clock edge, then the normal sequence repeats.
REQ-040 SHALL verify with RUN_CTRL_STALL_WDT_EN, STALL_CYCLES=16: kick every 10 cycles -> no fail; kicks stopped -> fail_code=11 after 16 cycles.
